// File: rtl/sdr_ram_responder_if.sv
// sdr_ram_responder_if: SDRAM command/control bus between a controller and the device.
//  master : controller side, drives every signal
//  slave  : device side, samples every signal on the rising clock edge
//  Signals: sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba[1:0],
//           sdr_addr[12:0], sdr_dqm[SDR_BW-1:0]
//  The bidirectional dq bus is a plain inout on the device and is not carried here.
interface sdr_ram_responder_if #(
    parameter int unsigned SDR_BW = 2
) ();
    logic              sdr_cke;
    logic              sdr_cs_n;
    logic              sdr_ras_n;
    logic              sdr_cas_n;
    logic              sdr_we_n;
    logic [1:0]        sdr_ba;
    logic [12:0]       sdr_addr;
    logic [SDR_BW-1:0] sdr_dqm;

    modport master (
        output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr, sdr_dqm
    );
    modport slave (
        input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr, sdr_dqm
    );
endinterface

// File: rtl/sdr_ram_responder.sv
// sdr_ram_responder: device-side model of a 4-bank SDR SDRAM.
//  Decodes controller commands, tracks open rows per bank, applies the mode register
//  (CL 2/3, BL 1/2/4/8), runs wrapping read/write bursts and pulses cmd_err on
//  protocol violations.
// Ports:
//  sdram_clk  in     clock, rising edge
//  sdram_rst  in     async active-high reset
//  bus        slave  command/control bus (cke, cs/ras/cas/we, ba, addr, dqm)
//  sdr_dq     inout  data; driven only during read data beats
//  mode_done  out    set by the first accepted MRS, sticky
//  cmd_err    out    one-cycle pulse per illegal command
module sdr_ram_responder #(
    parameter int unsigned SDR_DW = 16,
    parameter int unsigned SDR_BW = 2,
    parameter int unsigned ROW_AW = 4,
    parameter int unsigned COL_AW = 6
) (
    input  logic                      sdram_clk,
    input  logic                      sdram_rst,
    sdr_ram_responder_if.slave        bus,
    inout  wire  [SDR_DW-1:0]         sdr_dq,
    output logic                      mode_done,
    output logic                      cmd_err
);
    localparam int unsigned MEM_AW    = 2 + ROW_AW + COL_AW;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                cke_q;
    logic                cmd_en;
    logic [3:0]          cmd;
    logic [1:0]          ba;
    logic [12:0]         addr;
    logic [SDR_BW-1:0]   dqm;
    logic [COL_AW-1:0]   cmd_col;
    logic                is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, is_bst;
    logic                rd_ok, wr_ok, pre_hit, any_act, cl_ok, err_c;

    logic [3:0]          bank_act;
    logic [ROW_AW-1:0]   open_row [4];
    logic [1:0]          bl_code;
    logic                cl3;
    logic [2:0]          bl_last;
    logic [COL_AW-1:0]   col_mask;

    logic [1:0]          b_ba;
    logic [COL_AW-1:0]   b_col;
    logic                b_ap;
    logic [2:0]          b_idx;

    logic                beat_go, beat_wr, ap_close;
    logic [1:0]          beat_ba;
    logic [COL_AW-1:0]   beat_base;
    logic [2:0]          beat_n;
    logic [COL_AW-1:0]   beat_col;
    logic [MEM_AW-1:0]   beat_addr;

    logic [SDR_DW-1:0]   mem [MEM_DEPTH];
    logic [SDR_DW-1:0]   rd_data;
    logic [SDR_DW-1:0]   dq_in;

    logic [1:0]          pv;
    logic [SDR_DW-1:0]   pd [2];
    logic [SDR_BW-1:0]   dqm_q;
    logic [SDR_BW-1:0]   lane_oe;
    logic [SDR_DW-1:0]   dq_out;

    logic                unused_addr_bits;

    assign ba      = bus.sdr_ba;
    assign addr    = bus.sdr_addr;
    assign dqm     = bus.sdr_dqm;
    assign cmd_col = addr[COL_AW-1:0];
    assign dq_in   = sdr_dq;
    assign unused_addr_bits = ^addr;

    // Command decode; a command counts only when cke was high last cycle and this cycle
    always_comb begin
        cmd     = {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};
        cmd_en  = bus.sdr_cke & cke_q;
        is_act  = cmd_en && (cmd == 4'b0011);
        is_rd   = cmd_en && (cmd == 4'b0101);
        is_wr   = cmd_en && (cmd == 4'b0100);
        is_pre  = cmd_en && (cmd == 4'b0010);
        is_ref  = cmd_en && (cmd == 4'b0001);
        is_mrs  = cmd_en && (cmd == 4'b0000);
        is_bst  = cmd_en && (cmd == 4'b0110);
        any_act = |bank_act;
        rd_ok   = is_rd && bank_act[ba];
        wr_ok   = is_wr && bank_act[ba];
        pre_hit = is_pre && (addr[10] || (ba == b_ba));
        cl_ok   = (addr[6:4] == 3'd2) || (addr[6:4] == 3'd3);
        err_c   = (is_act && bank_act[ba])
               || ((is_rd || is_wr) && !bank_act[ba])
               || (is_ref && any_act)
               || (is_mrs && (any_act || addr[2] || !cl_ok));
        bl_last  = 3'((4'd1 << bl_code) - 4'd1);
        col_mask = COL_AW'(bl_last);
    end

    // Burst FSM: state register
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state <= ST_IDLE;
        end else if (bus.sdr_cke) begin
            state <= state_nxt;
        end
    end

    // Burst FSM: next state; a new RD/WR always wins over the running burst
    always_comb begin
        state_nxt = state;
        if (rd_ok || wr_ok) begin
            if (bl_code == 2'd0) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = rd_ok ? ST_RD : ST_WR;
            end
        end else if (state != ST_IDLE) begin
            if (is_bst || pre_hit || (b_idx == bl_last)) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Burst FSM: per-cycle beat controls (BST/PRE cycles carry no beat)
    always_comb begin
        beat_go   = 1'b0;
        beat_wr   = 1'b0;
        beat_ba   = b_ba;
        beat_base = b_col;
        beat_n    = b_idx;
        ap_close  = 1'b0;
        if (rd_ok || wr_ok) begin
            beat_go   = 1'b1;
            beat_wr   = wr_ok;
            beat_ba   = ba;
            beat_base = cmd_col;
            beat_n    = 3'd0;
            ap_close  = (bl_code == 2'd0) && addr[10];
        end else if (bus.sdr_cke && (state != ST_IDLE)) begin
            if (is_bst) begin
                ap_close = b_ap;
            end else if (!pre_hit) begin
                beat_go  = 1'b1;
                beat_wr  = (state == ST_WR);
                ap_close = b_ap && (b_idx == bl_last);
            end
        end
    end

    // Sequential wrap inside the BL-aligned column block
    always_comb begin
        beat_col  = (beat_base & ~col_mask) | ((beat_base + COL_AW'(beat_n)) & col_mask);
        beat_addr = {beat_ba, open_row[beat_ba], beat_col};
    end

    // Bank, mode and error state
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            cke_q     <= 1'b0;
            cmd_err   <= 1'b0;
            mode_done <= 1'b0;
            bank_act  <= '0;
            bl_code   <= 2'd0;
            cl3       <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                open_row[i] <= '0;
            end
        end else begin
            cke_q   <= bus.sdr_cke;
            cmd_err <= err_c;
            if (is_mrs && !any_act) begin
                mode_done <= 1'b1;
                if (!addr[2]) begin
                    bl_code <= addr[1:0];
                end
                if (cl_ok) begin
                    cl3 <= (addr[6:4] == 3'd3);
                end
            end
            if (is_act && !bank_act[ba]) begin
                bank_act[ba] <= 1'b1;
                open_row[ba] <= addr[ROW_AW-1:0];
            end
            if (is_pre) begin
                if (addr[10]) begin
                    bank_act <= '0;
                end else begin
                    bank_act[ba] <= 1'b0;
                end
            end
            if (ap_close) begin
                bank_act[beat_ba] <= 1'b0;
            end
        end
    end

    // Burst context latched on RD/WR, beat index advanced per beat
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            b_ba  <= 2'd0;
            b_col <= '0;
            b_ap  <= 1'b0;
            b_idx <= 3'd0;
        end else if (rd_ok || wr_ok) begin
            b_ba  <= ba;
            b_col <= cmd_col;
            b_ap  <= addr[10];
            b_idx <= 3'd1;
        end else if (beat_go) begin
            b_idx <= b_idx + 3'd1;
        end
    end

    // Array: byte-masked writes, no reset on contents
    always_ff @(posedge sdram_clk) begin
        if (beat_go && beat_wr) begin
            for (int i = 0; i < int'(SDR_BW); i++) begin
                if (!dqm[i]) begin
                    mem[beat_addr][i*8 +: 8] <= dq_in[i*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem[beat_addr];

    // Read pipe: stage 0, stage 1, output register; CL picks which stage feeds the output.
    // dqm is delayed one cycle so it masks the beat driven two cycles after sampling.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            pv      <= 2'b00;
            pd[0]   <= '0;
            pd[1]   <= '0;
            dqm_q   <= '0;
            lane_oe <= '0;
            dq_out  <= '0;
        end else if (bus.sdr_cke) begin
            pv[0]   <= beat_go && !beat_wr;
            pd[0]   <= rd_data;
            pv[1]   <= pv[0];
            pd[1]   <= pd[0];
            dqm_q   <= dqm;
            lane_oe <= {SDR_BW{cl3 ? pv[1] : pv[0]}} & ~dqm_q;
            dq_out  <= cl3 ? pd[1] : pd[0];
        end
    end

    // Per-lane tri-state drivers
    for (genvar g = 0; g < int'(SDR_BW); g++) begin : g_lane
        assign sdr_dq[g*8 +: 8] = lane_oe[g] ? dq_out[g*8 +: 8] : 8'hzz;
    end

endmodule

// File: tb/tb_sdr_ram_responder.sv
// tb_sdr_ram_responder: directed bench for sdr_ram_responder.
//  Commands and write data are driven on the falling edge; outputs are observed on the
//  falling edge before new inputs take effect. A released dq is observed by parking the
//  bench driver at 0 for a moment: any device drive then shows up as a non-zero/x value.
module tb_sdr_ram_responder;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_BST = 4'b0110;

    localparam logic [15:0] DA = 16'hA0A1;
    localparam logic [15:0] DB = 16'hB0B1;
    localparam logic [15:0] DC = 16'hC0C1;
    localparam logic [15:0] DD = 16'hD0D1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_done;
    logic        cmd_err;
    logic        tb_oe;
    logic [15:0] tb_d;
    wire  [15:0] sdr_dq;
    int          n_vec = 0;
    int          n_err = 0;

    sdr_ram_responder_if #(.SDR_BW(2)) bus ();

    assign sdr_dq = tb_oe ? tb_d : 16'hzzzz;

    sdr_ram_responder #(
        .SDR_DW(16),
        .SDR_BW(2),
        .ROW_AW(4),
        .COL_AW(6)
    ) dut (
        .sdram_clk (clk),
        .sdram_rst (rst),
        .bus       (bus),
        .sdr_dq    (sdr_dq),
        .mode_done (mode_done),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic oe = 1'b0, input logic [15:0] d = 16'h0000,
                         input logic [1:0] m = 2'b00);
        @(negedge clk);
        {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = c;
        bus.sdr_ba   = b;
        bus.sdr_addr = a;
        bus.sdr_dqm  = m;
        tb_oe        = oe;
        tb_d         = d;
    endtask

    task automatic nop();
        issue(C_NOP, 2'd0, 13'h000);
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_z(input string tag);
        tb_d  = 16'h0000;
        tb_oe = 1'b1;
        #1;
        chk(tag, sdr_dq, 16'h0000);
        tb_oe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tb_oe = 1'b0;
        tb_d = 16'h0000;
        bus.sdr_cke = 1'b1;
        {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = C_NOP;
        bus.sdr_ba = 2'd0;
        bus.sdr_addr = 13'h000;
        bus.sdr_dqm = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_mode_done", 16'(mode_done), 16'd0);
        chk("rst_cmd_err", 16'(cmd_err), 16'd0);
        chk_z("rst_dq");
        rst = 1'b0;
        nop();

        // 1: MRS CL3/BL4, ACT b0 r1, WR c4 A,B,C,D
        issue(C_MRS, 2'd0, 13'h032);
        issue(C_ACT, 2'd0, 13'h001);
        chk("mrs_mode_done", 16'(mode_done), 16'd1);
        chk("mrs_no_err", 16'(cmd_err), 16'd0);
        issue(C_WR, 2'd0, 13'h004, 1'b1, DA);
        chk("act_no_err", 16'(cmd_err), 16'd0);
        issue(C_NOP, 2'd0, 13'h000, 1'b1, DB);
        chk("wr_no_err", 16'(cmd_err), 16'd0);
        issue(C_NOP, 2'd0, 13'h000, 1'b1, DC);
        issue(C_NOP, 2'd0, 13'h000, 1'b1, DD);
        nop();

        // 2: RD c6 -> C,D,A,B at T+3..T+6, released at T+7
        issue(C_RD, 2'd0, 13'h006);
        nop(); nop(); chk_z("rd_before_cl");
        nop(); chk("rd_beat0", sdr_dq, DC);
        nop(); chk("rd_beat1", sdr_dq, DD);
        nop(); chk("rd_beat2_wrap", sdr_dq, DA);
        nop(); chk("rd_beat3", sdr_dq, DB);
        nop(); chk_z("rd_release");

        // 3: byte-masked write of 0x1234 over 0xABCD with dqm=10
        issue(C_WR, 2'd0, 13'h008, 1'b1, 16'hABCD);
        issue(C_BST, 2'd0, 13'h000);
        issue(C_WR, 2'd0, 13'h008, 1'b1, 16'h1234, 2'b10);
        issue(C_BST, 2'd0, 13'h000);
        issue(C_RD, 2'd0, 13'h008);
        issue(C_BST, 2'd0, 13'h000);
        nop(); nop(); chk("dqm_merge", sdr_dq, 16'hAB34);
        nop(); chk_z("dqm_release");

        // 4: RD idle bank, ACT active bank, MRS with open bank
        issue(C_RD, 2'd2, 13'h000);
        issue(C_ACT, 2'd0, 13'h005);
        chk("err_rd_idle", 16'(cmd_err), 16'd1);
        issue(C_MRS, 2'd0, 13'h020);
        chk("err_act_active", 16'(cmd_err), 16'd1);
        nop(); chk("err_mrs_open", 16'(cmd_err), 16'd1);
        nop(); chk("err_pulse_end", 16'(cmd_err), 16'd0);
        issue(C_RD, 2'd0, 13'h004);
        nop(); nop(); chk_z("keep_cl3");
        nop(); chk("keep_row_b0", sdr_dq, DA);
        nop(); chk("keep_bl4_b1", sdr_dq, DB);
        nop(); chk("keep_bl4_b2", sdr_dq, DC);
        nop(); chk("keep_bl4_b3", sdr_dq, DD);
        nop(); chk_z("keep_release");

        // 5: CL2/BL8, write c0..c7, RD c2 then BST after 3 beats
        issue(C_PRE, 2'd0, 13'h400);
        issue(C_MRS, 2'd0, 13'h023);
        issue(C_ACT, 2'd0, 13'h001);
        chk("mrs2_no_err", 16'(cmd_err), 16'd0);
        issue(C_WR, 2'd0, 13'h000, 1'b1, 16'h1000);
        for (int i = 1; i < 8; i++) begin
            issue(C_NOP, 2'd0, 13'h000, 1'b1, 16'(16'h1000 + i));
        end
        nop();
        issue(C_RD, 2'd0, 13'h002);
        nop(); chk_z("cl2_before");
        nop(); chk("bst_beat0", sdr_dq, 16'h1002);
        issue(C_BST, 2'd0, 13'h000);
        chk("bst_beat1", sdr_dq, 16'h1003);
        nop(); chk("bst_beat2", sdr_dq, 16'h1004);
        nop(); chk_z("bst_no_beat3");
        nop(); chk_z("bst_idle");

        // 6: BL2 read with auto-precharge, then RD to the now-idle bank
        issue(C_PRE, 2'd0, 13'h400);
        issue(C_MRS, 2'd0, 13'h021);
        issue(C_ACT, 2'd0, 13'h001);
        issue(C_RD, 2'd0, 13'h402);
        nop(); chk("ap_rd_no_err", 16'(cmd_err), 16'd0);
        issue(C_RD, 2'd0, 13'h000);
        chk("ap_beat0", sdr_dq, 16'h1002);
        nop(); chk("ap_beat1", sdr_dq, 16'h1003);
        chk("ap_rd_closed_err", 16'(cmd_err), 16'd1);
        nop(); chk_z("ap_release");
        nop(); chk_z("ap_ignored_rd");

        // 7: reset in the middle of a driven read beat
        issue(C_ACT, 2'd0, 13'h001);
        issue(C_RD, 2'd0, 13'h002);
        nop(); nop(); chk("pre_rst_beat", sdr_dq, 16'h1002);
        rst = 1'b1;
        chk_z("rst_mid_read");
        chk("rst_mid_mode_done", 16'(mode_done), 16'd0);
        nop();
        rst = 1'b0;
        nop();
        issue(C_RD, 2'd0, 13'h000);
        nop(); chk("rst_banks_idle", 16'(cmd_err), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
